uart_rx: RTL and testbench

- Serial receiver stage directly downstream of the UART transmitter.
- Recovers the transmitter's frame from the `rx` line and presents each received byte with a one-cycle `valid` strobe plus parity and framing status.
- Frame format: start (0), D0..D7 LSB first, even parity bit (XOR of D7..D0), stop (1).
- Line is oversampled; each bit is sampled at mid-bit.

---
 rtl/uart_rx.sv | 154 +++++++++++++++
 tb/tb_uart_rx.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: start, 8 data bits LSB first, even parity, stop; mid-bit sampling.
// Define UART_RX_MAJORITY_EN to take each bit as a 2-of-3 vote around mid-bit, one cycle later.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err
);
  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_END = CNT_W'(CLKS_PER_BIT - 1);
`ifdef UART_RX_MAJORITY_EN
  // Start decision moves one cycle later; every later decision inherits that shift.
  localparam logic [CNT_W-1:0] START_END = CNT_W'(HALF_BIT);
`else
  localparam logic [CNT_W-1:0] START_END = CNT_W'(HALF_BIT - 1);
`endif

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_PARITY    = 3'd3;
  localparam logic [2:0] S_STOP      = 3'd4;
  localparam logic [2:0] S_WAIT_HIGH = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             perr_q, perr_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             perr_out_q, perr_out_d;
  logic             ferr_q, ferr_d;
  logic             sample;

`ifdef UART_RX_MAJORITY_EN
  // Two previous line values; with the current one they form the vote window.
  logic [1:0] hist_q, hist_d;
  always_comb begin
    hist_d = {hist_q[0], rx};
    sample = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx) | (hist_q[0] & rx);
  end
  always_ff @(posedge clk) begin
    if (rst) hist_q <= 2'b11;
    else     hist_q <= hist_d;
  end
`else
  always_comb sample = rx;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    idx_d      = idx_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    perr_out_d = 1'b0;
    ferr_d     = 1'b0;
    if (!en) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_d = '0;
          if (!rx) state_d = S_START;
        end
        S_START: begin
          if (cnt_q == START_END) begin
            cnt_d = '0;
            if (!sample) begin
              state_d = S_DATA;
              idx_d   = 3'd0;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        S_DATA: begin
          if (cnt_q == BIT_END) begin
            cnt_d          = '0;
            shift_d[idx_q] = sample;
            idx_d          = idx_q + 3'd1;
            if (idx_q == 3'd7) state_d = S_PARITY;
          end
        end
        S_PARITY: begin
          if (cnt_q == BIT_END) begin
            cnt_d   = '0;
            perr_d  = sample ^ (^shift_q);
            state_d = S_STOP;
          end
        end
        S_STOP: begin
          if (cnt_q == BIT_END) begin
            cnt_d      = '0;
            data_d     = shift_q;
            valid_d    = 1'b1;
            perr_out_d = perr_q;
            ferr_d     = ~sample;
            state_d    = sample ? S_IDLE : S_WAIT_HIGH;
          end
        end
        S_WAIT_HIGH: begin
          // Line held low after a bad stop: wait for it to recover before re-arming.
          cnt_d = '0;
          if (rx) state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      perr_q     <= perr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_out_q <= perr_out_d;
      ferr_q     <= ferr_d;
    end
  end

  assign data_out   = data_q;
  assign valid      = valid_q;
  assign parity_err = perr_out_q;
  assign frame_err  = ferr_q;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frame table plus hand-written break, glitch, enable and reset sequences.
module tb_uart_rx;
  localparam int C  = 16;
  localparam int HB = C / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif
  localparam int LAT = 1 + HB + 10 * C + MAJ;

  logic       clk = 1'b0;
  logic       rst, en, rx;
  logic [7:0] data_out;
  logic       valid, parity_err, frame_err;

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst(rst), .en(en), .rx(rx),
    .data_out(data_out), .valid(valid), .parity_err(parity_err), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [7:0] d; logic pe; logic fe; } rec_t;
  rec_t vq[$];
  always @(negedge clk) if (valid === 1'b1) vq.push_back('{cyc, data_out, parity_err, frame_err});

  typedef struct { logic [7:0] b; bit pflip; bit stopv; logic [7:0] exp_d; bit exp_pe; bit exp_fe; } vec_t;
  vec_t vecs[5];

  int checks = 0, errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] mk(input logic [7:0] b, input bit pflip, input bit stopv);
    return {stopv, (^b) ^ pflip, b, 1'b0};
  endfunction

  task automatic hold(input logic v, input int n, input bit glitch);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx = (glitch && i == HB) ? 1'b0 : v;
    end
  endtask

  // Drives one 11-bit frame; s is the cycle count at which the start bit went low.
  task automatic send(input logic [10:0] bits, input bit glitch, output int s);
    @(negedge clk);
    rx = 1'b0;
    s  = cyc;
    hold(1'b0, C - 1, 1'b0);
    for (int j = 1; j < 11; j++) hold(bits[j], C, glitch && j <= 8);
  endtask

  task automatic expect_frame(input string name, input int s, input logic [7:0] d, input bit pe, input bit fe);
    rec_t r;
    check({name, " count"}, vq.size(), 1);
    if (vq.size() > 0) begin
      r = vq.pop_front();
      check({name, " data"}, r.d, d);
      check({name, " perr"}, r.pe, pe);
      check({name, " ferr"}, r.fe, fe);
      check({name, " latency"}, r.cyc - s, LAT);
    end
    vq.delete();
  endtask

  initial begin
    int s, s2;
    rec_t r1, r2;
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0};
    vecs[2] = '{8'h80, 1'b0, 1'b1, 8'h80, 1'b0, 1'b0};
    vecs[3] = '{8'h6E, 1'b1, 1'b0, 8'h6E, 1'b1, 1'b1};
    vecs[4] = '{8'h01, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0};

    rst = 1'b1; en = 1'b1; rx = 1'b1;
    repeat (3) @(negedge clk);
    check("reset outputs", {data_out, valid, parity_err, frame_err}, 0);
    rst = 1'b0;
    repeat (500) @(negedge clk);
    check("idle no valid", vq.size(), 0);

    foreach (vecs[i]) begin
      send(mk(vecs[i].b, vecs[i].pflip, vecs[i].stopv), 1'b0, s);
      rx = 1'b1;
      repeat (4) @(negedge clk);
      expect_frame($sformatf("vec%0d", i), s, vecs[i].exp_d, vecs[i].exp_pe, vecs[i].exp_fe);
      check($sformatf("vec%0d held", i), data_out, vecs[i].exp_d);
    end

    // Break: stop bit low, line stays low 40 more cycles.
    send(mk(8'h01, 1'b0, 1'b0), 1'b0, s);
    hold(1'b0, 40, 1'b0);
    check("break single valid", vq.size(), 1);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    expect_frame("break", s, 8'h01, 1'b0, 1'b1);
    send(mk(8'h55, 1'b0, 1'b1), 1'b0, s);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    expect_frame("after break", s, 8'h55, 1'b0, 1'b0);

    // Short low glitch on an idle line.
    hold(1'b0, 4, 1'b0);
    hold(1'b1, 300, 1'b0);
    check("glitch no valid", vq.size(), 0);

    // Receiver disabled during D3 of 0xFF.
    hold(1'b0, C, 1'b0);
    hold(1'b1, 3 * C + HB, 1'b0);
    en = 1'b0;
    hold(1'b1, C - HB + 4 * C, 1'b0);
    hold(1'b0, C, 1'b0);
    hold(1'b1, C, 1'b0);
    en = 1'b1;
    hold(1'b1, 50, 1'b0);
    check("disable no valid", vq.size(), 0);
    check("disable data kept", data_out, 8'h55);

    // Back-to-back frames with no idle gap.
    send(mk(8'h00, 1'b0, 1'b1), 1'b0, s);
    send(mk(8'hFF, 1'b0, 1'b1), 1'b0, s2);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    check("b2b count", vq.size(), 2);
    if (vq.size() == 2) begin
      r1 = vq.pop_front();
      r2 = vq.pop_front();
      check("b2b data0", r1.d, 8'h00);
      check("b2b data1", r2.d, 8'hFF);
      check("b2b errs", {r1.pe, r1.fe, r2.pe, r2.fe}, 0);
      check("b2b spacing", r2.cyc - r1.cyc, 11 * C);
      check("b2b latency", r1.cyc - s, LAT);
    end
    vq.delete();

`ifdef UART_RX_MAJORITY_EN
    send(mk(8'hFF, 1'b0, 1'b1), 1'b1, s);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    expect_frame("majority glitch", s, 8'hFF, 1'b0, 1'b0);
`endif

    // Reset in the middle of a frame discards it.
    hold(1'b0, C, 1'b0);
    hold(1'b1, 2 * C, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    hold(1'b1, 10 * C, 1'b0);
    check("midreset no valid", vq.size(), 0);
    check("midreset data", data_out, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
